// File: rtl/regression_accumulator.sv
// Streams N (x, y) sample pairs from two one-cycle-latency memories and
// accumulates sum(x), sum(y), sum(x*y) and sum(x*x) for a least-squares fit.
module regression_accumulator #(
  parameter int N      = 150,
  parameter int ADDR_W = 8,
  parameter int DW     = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DW-1:0]     x_in,
  input  logic signed [DW-1:0]     y_in,
  output logic [ADDR_W-1:0]        addr,
  output logic                     x_read,
  output logic                     y_read,
  output logic signed [DW+7:0]     sum_x,
  output logic signed [DW+7:0]     sum_y,
  output logic signed [2*DW+7:0]   sum_xy,
  output logic signed [2*DW+7:0]   sum_xx,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

  state_e                   state_q, state_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic                     valid_q, valid_d;
  logic signed [DW+7:0]     sum_x_q, sum_x_d;
  logic signed [DW+7:0]     sum_y_q, sum_y_d;
  logic signed [2*DW+7:0]   sum_xy_q, sum_xy_d;
  logic signed [2*DW+7:0]   sum_xx_q, sum_xx_d;
  logic signed [2*DW-1:0]   prod_xy, prod_xx;
  logic                     clear_sums;

  // NOTE: all state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, independent of order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      sum_x_q  <= '0;
      sum_y_q  <= '0;
      sum_xy_q <= '0;
      sum_xx_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      sum_x_q  <= sum_x_d;
      sum_y_q  <= sum_y_d;
      sum_xy_q <= sum_xy_d;
      sum_xx_q <= sum_xx_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    clear_sums = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_READ;
          addr_d     = '0;
          clear_sums = 1'b1;
        end
      end
      ST_READ: begin
        // Park on the last address instead of wrapping back to 0.
        if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
        else                     addr_d  = addr_q + ADDR_W'(1);
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    x_read = (state_q == ST_READ);
    y_read = (state_q == ST_READ);
    busy   = (state_q != ST_IDLE);
    done   = (state_q == ST_DONE);
  end

  // Data returned this cycle belongs to the strobe issued last cycle.
  always_comb begin
    valid_d  = x_read;
    prod_xy  = (2*DW)'(x_in) * (2*DW)'(y_in);
    prod_xx  = (2*DW)'(x_in) * (2*DW)'(x_in);
    sum_x_d  = sum_x_q;
    sum_y_d  = sum_y_q;
    sum_xy_d = sum_xy_q;
    sum_xx_d = sum_xx_q;
    if (valid_q) begin
      sum_x_d  = sum_x_q  + (DW+8)'(x_in);
      sum_y_d  = sum_y_q  + (DW+8)'(y_in);
      sum_xy_d = sum_xy_q + (2*DW+8)'(prod_xy);
      sum_xx_d = sum_xx_q + (2*DW+8)'(prod_xx);
    end
    if (clear_sums) begin
      sum_x_d  = '0;
      sum_y_d  = '0;
      sum_xy_d = '0;
      sum_xx_d = '0;
    end
  end

  assign addr   = addr_q;
  assign sum_x  = sum_x_q;
  assign sum_y  = sum_y_q;
  assign sum_xy = sum_xy_q;
  assign sum_xx = sum_xx_q;

endmodule

// File: tb/tb_regression_accumulator.sv
// Directed and randomized passes of regression_accumulator against sums
// computed directly from the sample memories.
module tb_regression_accumulator;

  localparam int N  = 150;
  localparam int AW = 8;
  localparam int DW = 20;

  logic                   clk;
  logic                   rst;
  logic                   start;
  logic signed [DW-1:0]   x_in;
  logic signed [DW-1:0]   y_in;
  logic [AW-1:0]          addr;
  logic                   x_read;
  logic                   y_read;
  logic signed [DW+7:0]   sum_x;
  logic signed [DW+7:0]   sum_y;
  logic signed [2*DW+7:0] sum_xy;
  logic signed [2*DW+7:0] sum_xx;
  logic                   busy;
  logic                   done;

  regression_accumulator #(.N(N), .ADDR_W(AW), .DW(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .x_in   (x_in),
    .y_in   (y_in),
    .addr   (addr),
    .x_read (x_read),
    .y_read (y_read),
    .sum_x  (sum_x),
    .sum_y  (sum_y),
    .sum_xy (sum_xy),
    .sum_xx (sum_xx),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic signed [DW-1:0] x_mem [N];
  logic signed [DW-1:0] y_mem [N];

  // Sample memories: one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    if (x_read) x_in <= x_mem[addr];
    else        x_in <= DW'($urandom);
    if (y_read) y_in <= y_mem[addr];
    else        y_in <= DW'($urandom);
  end

  int total;
  int bad;
  longint ex_sx, ex_sy, ex_sxy, ex_sxx;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // 0: x=i,y=2i  1: x=-1,y=1  2: x=y=most negative  3: random
  task automatic fill(input int mode);
    for (int i = 0; i < N; i++) begin
      case (mode)
        0: begin x_mem[i] = DW'(i);      y_mem[i] = DW'(2 * i);   end
        1: begin x_mem[i] = -DW'(1);     y_mem[i] = DW'(1);       end
        2: begin x_mem[i] = {1'b1, {(DW-1){1'b0}}}; y_mem[i] = {1'b1, {(DW-1){1'b0}}}; end
        default: begin x_mem[i] = DW'($urandom); y_mem[i] = DW'($urandom); end
      endcase
    end
    ex_sx = 0; ex_sy = 0; ex_sxy = 0; ex_sxx = 0;
    for (int i = 0; i < N; i++) begin
      ex_sx  += longint'(x_mem[i]);
      ex_sy  += longint'(y_mem[i]);
      ex_sxy += longint'(x_mem[i]) * longint'(y_mem[i]);
      ex_sxx += longint'(x_mem[i]) * longint'(x_mem[i]);
    end
  endtask

  task automatic check_sums(input string tag);
    check({tag, ".sum_x"},  longint'(sum_x),  ex_sx);
    check({tag, ".sum_y"},  longint'(sum_y),  ex_sy);
    check({tag, ".sum_xy"}, longint'(sum_xy), ex_sxy);
    check({tag, ".sum_xx"}, longint'(sum_xx), ex_sxx);
  endtask

  // Runs one pass; latency counts edges from the start-accept edge (edge 1)
  // to the edge that raises done.
  task automatic run_pass(input string tag, input bit hold_start);
    int lat, dones, nreads, addr_bad, strobe_bad;
    lat = -1; dones = 0; nreads = 0; addr_bad = 0; strobe_bad = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= N + 12; k++) begin
      @(posedge clk);
      #1;
      if (!hold_start && k == 1) start = 1'b0;
      if (x_read !== y_read) strobe_bad++;
      if (x_read === 1'b1) begin
        if (addr !== AW'(nreads)) addr_bad++;
        nreads++;
      end
      if (done === 1'b1) begin
        dones++;
        if (lat < 0) lat = k;
        start = 1'b0;
      end
    end
    check({tag, ".latency"},  lat,        N + 2);
    check({tag, ".dones"},    dones,      1);
    check({tag, ".reads"},    nreads,     N);
    check({tag, ".addr_seq"}, addr_bad,   0);
    check({tag, ".strobes"},  strobe_bad, 0);
    check({tag, ".idle"},     busy,       0);
    check_sums(tag);
  endtask

  initial begin
    int dones;
    total = 0;
    bad = 0;
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy",   busy,   0);
    check("rst.done",   done,   0);
    check("rst.addr",   addr,   0);
    check("rst.x_read", x_read, 0);
    check("rst.sum_x",  longint'(sum_x),  0);
    check("rst.sum_xx", longint'(sum_xx), 0);
    @(negedge clk);
    rst = 1'b0;

    fill(0);
    run_pass("ramp", 1'b0);

    // Sums must hold in IDLE while the memory bus carries garbage.
    repeat (5) @(posedge clk);
    #1;
    check_sums("ramp_hold");

    fill(1);
    run_pass("neg_one", 1'b0);

    fill(2);
    run_pass("most_neg", 1'b0);

    fill(3);
    run_pass("held_start", 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("held_start.no_restart", busy, 0);

    // Back-to-back passes: second result reflects only the second data set.
    fill(3);
    run_pass("b2b_a", 1'b0);
    fill(3);
    run_pass("b2b_b", 1'b0);

    // Abort mid-pass at addr 70.
    fill(3);
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < N + 4; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (x_read === 1'b1 && addr === AW'(70)) break;
    end
    check("abort.addr_reached", addr, 70);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort.busy",   busy,   0);
    check("abort.done",   done,   0);
    check("abort.addr",   addr,   0);
    check("abort.x_read", x_read, 0);
    check("abort.y_read", y_read, 0);
    check("abort.sum_x",  longint'(sum_x),  0);
    check("abort.sum_y",  longint'(sum_y),  0);
    check("abort.sum_xy", longint'(sum_xy), 0);
    check("abort.sum_xx", longint'(sum_xx), 0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < N; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dones++;
    end
    check("abort.no_done", dones, 0);

    // rst wins over start in the same cycle.
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("rst_prio.busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;

    run_pass("after_abort", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
